// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit: register
// address type, architectural zero/link registers and the stall FSM states.
package hfu_pkg;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd31;
    localparam reg_addr_t LINK_REG = 5'd30;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hfu_state_e;

    // A branch-with-link stage implicitly writes LINK_REG; ZERO_REG never forwards.
    function automatic logic stage_match(
        input reg_addr_t rs,
        input logic      wr_en,
        input logic      bl,
        input reg_addr_t rd
    );
        return (rs != ZERO_REG) &&
               ((bl && (rs == LINK_REG)) ||
                (wr_en && (rd != ZERO_REG) && (rd == rs)));
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority forwarding-source selection for a single source operand.
// Stage 0 is the youngest and wins; select k means stage k-1, 0 means register file.
module fwd_select
    import hfu_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic [4:0]               rs_i,
    input  logic [NUM_FWD-1:0]       st_wr_en_i,
    input  logic [NUM_FWD-1:0]       st_bl_i,
    input  logic [NUM_FWD-1:0][4:0]  st_rd_i,
    output logic [SEL_W-1:0]         sel_o
);

    // Scan oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        sel_o = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            sel_o = stage_match(rs_i, st_wr_en_i[i], st_bl_i[i], st_rd_i[i])
                    ? SEL_W'(i + 1) : sel_o;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding select and load-use stall FSM.
// Optional build macro HFU_STATS_EN adds a saturating stall_count output.
module hazard_forward_unit
    import hfu_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_FWD-1:0]                      st_wr_en,
    input  logic [NUM_FWD-1:0]                      st_bl,
    input  logic [NUM_FWD-1:0][4:0]                 st_rd,
    input  logic [NUM_SRC-1:0][4:0]                 ex_rs,
    input  logic [NUM_SRC-1:0][4:0]                 id_rs,
    input  logic [NUM_SRC-1:0]                      id_rs_used,
    input  logic                                    ex_mem_read,
    input  logic [4:0]                              ex_rd,
    input  logic                                    flush,
    output logic [NUM_SRC-1:0][$clog2(NUM_FWD+1)-1:0] fwd_sel,
    output logic                                    stall
`ifdef HFU_STATS_EN
    ,
    output logic [31:0]                             stall_count
`endif
);

    localparam int         SEL_W     = $clog2(NUM_FWD + 1);
    localparam logic [2:0] HOLD_INIT = 3'(LOAD_LAT - 1);

    hfu_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       use_hit_s;
    logic       load_use_s;
    logic       stall_s;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_select #(
            .NUM_FWD (NUM_FWD),
            .SEL_W   (SEL_W)
        ) u_fwd_select (
            .rs_i       (ex_rs[s]),
            .st_wr_en_i (st_wr_en),
            .st_bl_i    (st_bl),
            .st_rd_i    (st_rd),
            .sel_o      (fwd_sel[s])
        );
    end

    // Load-use detection against every used IF/ID source.
    always_comb begin
        use_hit_s = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            use_hit_s = use_hit_s | (id_rs_used[s] && (id_rs[s] == ex_rd));
        end
        load_use_s = ex_mem_read && (ex_rd != ZERO_REG) && use_hit_s;
    end

    // Stall FSM next-state: first stall cycle is spent in IDLE, the rest in HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_s = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            stall_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_use_s) begin
                        stall_s = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_HOLD;
                            cnt_d   = HOLD_INIT;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = 3'd0;
                        end
                    end else begin
                        stall_s = 1'b0;
                    end
                end
                ST_HOLD: begin
                    stall_s = 1'b1;
                    cnt_d   = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    stall_s = 1'b0;
                end
            endcase
        end
    end

    // Stall FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset masks the combinational hazard path as well.
    assign stall = stall_s & rst_n;

`ifdef HFU_STATS_EN
    logic [31:0] stall_count_q;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= 32'd0;
        end else if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end else begin
            stall_count_q <= stall_count_q;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: three DUTs (LOAD_LAT 3, 2, 1) share all inputs and are
// checked against a cycle-level reference model, a vector table and corner sequences.
module tb_hazard_forward_unit;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            ex_mem_read;
    logic [1:0]      st_wr_en, st_bl, id_rs_used;
    logic [1:0][4:0] st_rd, ex_rs, id_rs;
    logic [4:0]      ex_rd;
    logic [1:0][1:0] fs [3];
    logic [2:0]      stl;
`ifdef HFU_STATS_EN
    logic [31:0]     sc [3];
`endif

    int total = 0;
    int bad   = 0;
    int rem    [3] = '{0, 0, 0};
    int hi_cnt [3] = '{0, 0, 0};
    int lat    [3] = '{3, 2, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_forward_unit #(
            .NUM_SRC  (2),
            .NUM_FWD  (2),
            .LOAD_LAT (3 - g)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .st_wr_en    (st_wr_en),
            .st_bl       (st_bl),
            .st_rd       (st_rd),
            .ex_rs       (ex_rs),
            .id_rs       (id_rs),
            .id_rs_used  (id_rs_used),
            .ex_mem_read (ex_mem_read),
            .ex_rd       (ex_rd),
            .flush       (flush),
            .fwd_sel     (fs[g]),
            .stall       (stl[g])
`ifdef HFU_STATS_EN
            ,
            .stall_count (sc[g])
`endif
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Forwarding rule: ZERO_REG never forwards; youngest stage writing rs wins,
    // a BL stage counts as writing the link register.
    function automatic int ref_sel(input int s);
        if (ex_rs[s] == 5'd31) return 0;
        for (int k = 0; k < 2; k++) begin
            if ((st_bl[k] && ex_rs[s] == 5'd30) ||
                (st_wr_en[k] && st_rd[k] != 5'd31 && st_rd[k] == ex_rs[s]))
                return k + 1;
        end
        return 0;
    endfunction

    task automatic idle_inputs();
        flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        st_wr_en = 2'b00; st_bl = 2'b00; id_rs_used = 2'b00;
        st_rd = '0; ex_rs = '0; id_rs = '0;
    endtask

    task automatic load_hazard();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs[0] = 5'd7; id_rs_used = 2'b01;
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        logic hz;
        int   e;
        @(negedge clk);
        hz = ex_mem_read && (ex_rd != 5'd31) &&
             ((id_rs_used[0] && id_rs[0] == ex_rd) || (id_rs_used[1] && id_rs[1] == ex_rd));
        for (int d = 0; d < 3; d++) begin
            if (!rst_n || flush) begin
                e = 0; rem[d] = 0;
            end else if (rem[d] > 0) begin
                e = 1; rem[d]--;
            end else if (hz) begin
                e = 1; rem[d] = lat[d] - 1;
            end else begin
                e = 0;
            end
            chk($sformatf("stall[lat%0d]", lat[d]), int'(stl[d]), e);
            hi_cnt[d] += int'(stl[d]);
            for (int s = 0; s < 2; s++)
                chk($sformatf("fwd_sel[lat%0d][%0d]", lat[d], s), int'(fs[d][s]), ref_sel(s));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hi();
        for (int d = 0; d < 3; d++) hi_cnt[d] = 0;
    endtask

    typedef struct {
        logic [1:0] wr;
        logic [1:0] bl;
        logic [4:0] rd0, rd1, rs0, rs1;
        int         e0, e1;
    } fvec_t;

    fvec_t      tbl [9];
    logic [4:0] pool [5] = '{5'd5, 5'd7, 5'd30, 5'd31, 5'd0};

    initial begin
        tbl[0] = '{2'b11, 2'b00, 5'd5,  5'd5,  5'd5,  5'd0,  1, 0};
        tbl[1] = '{2'b00, 2'b10, 5'd0,  5'd0,  5'd3,  5'd30, 0, 2};
        tbl[2] = '{2'b01, 2'b11, 5'd31, 5'd0,  5'd31, 5'd31, 0, 0};
        tbl[3] = '{2'b10, 2'b00, 5'd12, 5'd12, 5'd12, 5'd12, 2, 2};
        tbl[4] = '{2'b11, 2'b00, 5'd31, 5'd4,  5'd4,  5'd31, 2, 0};
        tbl[5] = '{2'b11, 2'b01, 5'd30, 5'd9,  5'd9,  5'd30, 2, 1};
        tbl[6] = '{2'b01, 2'b10, 5'd30, 5'd0,  5'd7,  5'd30, 0, 1};
        tbl[7] = '{2'b00, 2'b00, 5'd7,  5'd7,  5'd7,  5'd7,  0, 0};
        tbl[8] = '{2'b01, 2'b00, 5'd0,  5'd0,  5'd0,  5'd0,  1, 1};

        idle_inputs();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Combinational forwarding vectors.
        for (int v = 0; v < 9; v++) begin
            st_wr_en = tbl[v].wr; st_bl = tbl[v].bl;
            st_rd[0] = tbl[v].rd0; st_rd[1] = tbl[v].rd1;
            ex_rs[0] = tbl[v].rs0; ex_rs[1] = tbl[v].rs1;
            #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("vec%0d_sel0[lat%0d]", v, lat[d]), int'(fs[d][0]), tbl[v].e0);
                chk($sformatf("vec%0d_sel1[lat%0d]", v, lat[d]), int'(fs[d][1]), tbl[v].e1);
            end
        end
        idle_inputs();
        @(posedge clk);
        #1;

        // Single load-use: stall length equals LOAD_LAT.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        clear_hi();
        load_hazard();
        cycle();
        idle_inputs();
        repeat (5) cycle();
        for (int d = 0; d < 3; d++)
            chk($sformatf("stall_len[lat%0d]", lat[d]), hi_cnt[d], lat[d]);
`ifdef HFU_STATS_EN
        for (int d = 0; d < 3; d++)
            chk($sformatf("stall_count[lat%0d]", lat[d]), int'(sc[d]), lat[d]);
`endif

        // Flush in the second stall cycle cuts the sequence short.
        clear_hi();
        load_hazard();
        cycle();
        idle_inputs();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (4) cycle();
        for (int d = 0; d < 3; d++)
            chk($sformatf("flush_len[lat%0d]", lat[d]), hi_cnt[d], 1);

        // Reset asserted while in HOLD.
        load_hazard();
        cycle();
        idle_inputs();
        chk("hold_before_rst[lat2]", int'(stl[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_immediate[lat2]", int'(stl[1]), 0);
        chk("rst_immediate[lat3]", int'(stl[0]), 0);
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();

        // Non-hazards: unused operand, and load to the zero register.
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs[0] = 5'd7; id_rs_used = 2'b00;
        cycle();
        ex_rd = 5'd31; id_rs[0] = 5'd31; id_rs[1] = 5'd31; id_rs_used = 2'b11;
        cycle();
        idle_inputs();
        cycle();

        // Hazard held on operand 1: back-to-back sequences without a gap.
        clear_hi();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs[1] = 5'd9; id_rs_used = 2'b10;
        repeat (7) cycle();
        for (int d = 0; d < 3; d++)
            chk($sformatf("held_len[lat%0d]", lat[d]), hi_cnt[d], 7);
        idle_inputs();
        repeat (4) cycle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            rst_n       = ($urandom_range(0, 63) != 0);
            flush       = ($urandom_range(0, 7) == 0);
            ex_mem_read = $urandom_range(0, 1) != 0;
            st_wr_en    = 2'($urandom_range(0, 3));
            st_bl       = 2'($urandom_range(0, 3));
            id_rs_used  = 2'($urandom_range(0, 3));
            ex_rd       = pool[$urandom_range(0, 4)];
            for (int k = 0; k < 2; k++) begin
                st_rd[k] = pool[$urandom_range(0, 4)];
                ex_rs[k] = pool[$urandom_range(0, 4)];
                id_rs[k] = pool[$urandom_range(0, 4)];
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, source operands per instruction (range 2..3).
REQ-002 SHALL have parameter NUM_FWD, default 2, forwarding stages; index 0 is youngest (EX/MEM), index 1 is MEM/WB.
REQ-003 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles (range 1..7).
REQ-004 SHALL have port clk, in, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-006 SHALL have ports st_wr_en, st_bl (in, NUM_FWD each) and st_rd (in, NUM_FWD x 5): per-stage register-write enable, branch-with-link flag and destination register.
REQ-007 SHALL have port ex_rs, in, NUM_SRC x 5, ID/EX source registers.
REQ-008 SHALL have port id_rs (in, NUM_SRC x 5) and id_rs_used (in, NUM_SRC): IF/ID sources and their use flags.
REQ-009 SHALL have ports ex_mem_read (in, 1) and ex_rd (in, 5): load indication and destination in ID/EX.
REQ-010 SHALL have port flush, in, 1, pipeline flush from branch resolution.
REQ-011 SHALL have port fwd_sel, out, NUM_SRC x $clog2(NUM_FWD+1): 0 = register file, k = stage k-1.
REQ-012 SHALL have port stall, out, 1: hold PC and IF/ID, insert bubble into ID/EX.

Function
REQ-013 fwd_sel[s] SHALL be combinational with priority youngest stage first; stage i matches if (st_bl[i] and ex_rs[s]==30) or (st_wr_en[i] and st_rd[i]!=31 and st_rd[i]==ex_rs[s]).
REQ-014 Within one stage, a BL match and a normal-write match SHALL give the same select value.
REQ-015 ex_rs[s]==31 SHALL always give fwd_sel[s]=0, including when st_bl is set.
REQ-016 Load-use hazard SHALL be: ex_mem_read, ex_rd!=31, and some s with id_rs_used[s] and id_rs[s]==ex_rd.
REQ-017 The FSM SHALL have states IDLE and HOLD, plus a 3-bit counter cnt.
REQ-018 In IDLE, a hazard SHALL assert stall in the same cycle (combinational). If LOAD_LAT>1, the next state SHALL be HOLD with cnt=LOAD_LAT-1; otherwise the FSM SHALL stay in IDLE.
REQ-019 In HOLD, stall SHALL be 1 regardless of inputs and cnt SHALL decrement each cycle. When cnt==1, the next state SHALL be IDLE.
REQ-020 Total stall SHALL be exactly LOAD_LAT consecutive cycles per detected load.
REQ-021 flush=1 SHALL force stall=0 in that cycle and the next state to IDLE with cnt=0; flush SHALL win over a simultaneous hazard.
REQ-022 A new hazard detected on the cycle HOLD returns to IDLE SHALL start a fresh stall sequence with no gap cycle.

Reset
REQ-023 rst_n low SHALL force state=IDLE and cnt=0 immediately; stall SHALL be 0 while in reset.
REQ-024 Reset during HOLD SHALL abort the sequence; no stall SHALL occur after release unless a new hazard is present.

Configuration
REQ-025 Macro HFU_STATS_EN, when defined, SHALL add output stall_count (32 bits). It SHALL increment on every cycle with stall=1, saturate at all-ones, and reset to 0.
REQ-026 Without HFU_STATS_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package hfu_pkg SHALL hold ZERO_REG=31, LINK_REG=30, the FSM state enum and the reg_addr_t (5-bit) typedef.
REQ-028 Sub-module fwd_select SHALL implement one operand's priority match (REQ-013..015) and SHALL be instantiated NUM_SRC times.

Verification
REQ-029 st_wr_en=2'b11, st_rd={5,5}, ex_rs[0]=5 -> fwd_sel[0]=1 (youngest wins).
REQ-030 st_bl[1]=1, st_wr_en=0, ex_rs[1]=30 -> fwd_sel[1]=2; with ex_rs[1]=31 and st_wr_en[0]=1, st_rd[0]=31 -> fwd_sel[1]=0.
REQ-031 LOAD_LAT=3, ex_mem_read=1, ex_rd=7, id_rs[0]=7, id_rs_used[0]=1 for one cycle -> stall high exactly 3 cycles; with HFU_STATS_EN, stall_count=3.
REQ-032 LOAD_LAT=3, flush in the second stall cycle -> stall drops that cycle and stays low.
REQ-033 LOAD_LAT=2, rst_n pulsed low in HOLD -> stall=0 immediately and after release with no hazard.
REQ-034 Hazard with id_rs_used[0]=0 or ex_rd=31 -> no stall.
